// File: rtl/uart_word_display.sv
// Builds 16-bit words from UART bytes (high byte first) and shows the last
// word as four hex digits on a multiplexed, active-low seven-segment display.
//
// Ports:
//   clk, reset (async, active-low)
//   Rx_DATA[7:0], Rx_VALID, Rx_FERROR, Rx_PERROR : from the UART receiver
//   word[15:0], word_valid, err                  : assembled word and status
//   an3..an0                                     : digit anodes, active-low
//   a..g                                         : segment cathodes, active-low
module uart_word_display #(
    parameter int REFRESH_CYCLES = 50000,
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] Rx_DATA,
    input  logic       Rx_VALID,
    input  logic       Rx_FERROR,
    input  logic       Rx_PERROR,
    output logic [15:0] word,
    output logic       word_valid,
    output logic       err,
    output logic       an3,
    output logic       an2,
    output logic       an1,
    output logic       an0,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       e,
    output logic       f,
    output logic       g
);

    localparam int RW = $clog2(REFRESH_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    // Segment order {a,b,c,d,e,f,g}, active-low
    localparam logic [6:0] SEG_DASH = 7'b1111110;
    localparam logic [6:0] SEG_ZERO = 7'b0000001;

    typedef enum logic {
        WAIT_HI,
        WAIT_LO
    } state_t;

    state_t          state, state_nx;
    logic [7:0]      hi_byte, hi_nx;
    logic [TW-1:0]   tmo_cnt, tmo_nx;
    logic [15:0]     word_nx;
    logic            wv_nx;
    logic            err_nx;
    logic            good;
    logic            evt;

    logic [RW-1:0]   ref_cnt;
    logic [1:0]      idx;
    logic [3:0]      nib;
    logic [3:0]      an_q, an_nx;
    logic [6:0]      seg_q, seg_nx;

    // Active-high pattern, {a,b,c,d,e,f,g}
    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'b1111110;
            4'h1: s = 7'b0110000;
            4'h2: s = 7'b1101101;
            4'h3: s = 7'b1111001;
            4'h4: s = 7'b0110011;
            4'h5: s = 7'b1011011;
            4'h6: s = 7'b1011111;
            4'h7: s = 7'b1110000;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1111011;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b0011111;
            4'hC: s = 7'b1001110;
            4'hD: s = 7'b0111101;
            4'hE: s = 7'b1001111;
            4'hF: s = 7'b1000111;
        endcase
        return s;
    endfunction

    // An error flag on the bus overrides any simultaneous valid strobe
    assign evt  = Rx_FERROR | Rx_PERROR;
    assign good = Rx_VALID & ~evt;

    always_comb begin
        state_nx = state;
        hi_nx    = hi_byte;
        tmo_nx   = tmo_cnt;
        word_nx  = word;
        wv_nx    = 1'b0;
        err_nx   = err;
        unique case (state)
            WAIT_HI: begin
                if (evt) begin
                    err_nx = 1'b1;
                end else if (good) begin
                    hi_nx    = Rx_DATA;
                    tmo_nx   = '0;
                    state_nx = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (evt) begin
                    err_nx   = 1'b1;
                    state_nx = WAIT_HI;
                end else if (good) begin
                    // A byte on the expiry cycle still completes the word
                    word_nx  = {hi_byte, Rx_DATA};
                    wv_nx    = 1'b1;
                    err_nx   = 1'b0;
                    state_nx = WAIT_HI;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_nx = WAIT_HI;
                end else begin
                    tmo_nx = tmo_cnt + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= WAIT_HI;
            hi_byte    <= '0;
            tmo_cnt    <= '0;
            word       <= '0;
            word_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nx;
            hi_byte    <= hi_nx;
            tmo_cnt    <= tmo_nx;
            word       <= word_nx;
            word_valid <= wv_nx;
            err        <= err_nx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ref_cnt <= '0;
            idx     <= '0;
        end else if (ref_cnt == REF_LAST) begin
            ref_cnt <= '0;
            idx     <= idx + 1'b1;
        end else begin
            ref_cnt <= ref_cnt + 1'b1;
        end
    end

    always_comb begin
        nib   = word[3:0];
        an_nx = 4'b1110;
        unique case (idx)
            2'd0: begin nib = word[3:0];   an_nx = 4'b1110; end
            2'd1: begin nib = word[7:4];   an_nx = 4'b1101; end
            2'd2: begin nib = word[11:8];  an_nx = 4'b1011; end
            2'd3: begin nib = word[15:12]; an_nx = 4'b0111; end
        endcase
        seg_nx = err ? SEG_DASH : ~hex7(nib);
    end

    // Anodes and segments share one register stage so they switch together
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an_q  <= 4'b1110;
            seg_q <= SEG_ZERO;
        end else begin
            an_q  <= an_nx;
            seg_q <= seg_nx;
        end
    end

    assign {an3, an2, an1, an0} = an_q;
    assign {a, b, c, d, e, f, g} = seg_q;

endmodule

// File: tb/tb_uart_word_display.sv
// Scoreboard bench for uart_word_display: directed byte traffic, queued
// expected words, and display-scan checks.
module tb_uart_word_display;

    localparam int RC = 8;
    localparam int TC = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  Rx_DATA = '0;
    logic        Rx_VALID = 1'b0;
    logic        Rx_FERROR = 1'b0;
    logic        Rx_PERROR = 1'b0;
    logic [15:0] word;
    logic        word_valid;
    logic        err;
    logic        an3, an2, an1, an0;
    logic        a, b, c, d, e, f, g;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] mon_exp;

    uart_word_display #(
        .REFRESH_CYCLES(RC),
        .TIMEOUT_CYCLES(TC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .Rx_DATA(Rx_DATA),
        .Rx_VALID(Rx_VALID),
        .Rx_FERROR(Rx_FERROR),
        .Rx_PERROR(Rx_PERROR),
        .word(word),
        .word_valid(word_valid),
        .err(err),
        .an3(an3),
        .an2(an2),
        .an1(an1),
        .an0(an0),
        .a(a),
        .b(b),
        .c(c),
        .d(d),
        .e(e),
        .f(f),
        .g(g)
    );

    always #5 clk = ~clk;

    // Hand-written active-low patterns {a..g}
    function automatic logic [6:0] seg_exp(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0000001;
            4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;
            4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;
            4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;
            4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;
            4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;
            4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;
            default: return 7'b0111000;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] dat, input logic v,
                             input logic fe, input logic pe);
        @(posedge clk);
        #1;
        Rx_DATA   = dat;
        Rx_VALID  = v;
        Rx_FERROR = fe;
        Rx_PERROR = pe;
        @(posedge clk);
        #1;
        Rx_VALID  = 1'b0;
        Rx_FERROR = 1'b0;
        Rx_PERROR = 1'b0;
    endtask

    // Two good bytes on adjacent cycles
    task automatic send2(input logic [7:0] hi, input logic [7:0] lo);
        @(posedge clk);
        #1;
        Rx_DATA  = hi;
        Rx_VALID = 1'b1;
        @(posedge clk);
        #1;
        Rx_DATA  = lo;
        @(posedge clk);
        #1;
        Rx_VALID = 1'b0;
    endtask

    task automatic check_scan(input string tag, input logic [15:0] w,
                              input logic ex_err);
        int bad_oh = 0;
        int bad_seg = 0;
        int bad_rot = 0;
        int run = 0;
        int prev = -1;
        int trans = 0;
        int idx;
        logic [3:0] an;
        logic [6:0] seg, want;
        repeat (2) @(posedge clk);
        repeat (8 * RC + 4) begin
            @(negedge clk);
            an  = {an3, an2, an1, an0};
            seg = {a, b, c, d, e, f, g};
            case (an)
                4'b1110: idx = 0;
                4'b1101: idx = 1;
                4'b1011: idx = 2;
                4'b0111: idx = 3;
                default: idx = -1;
            endcase
            if (idx < 0) begin
                bad_oh++;
            end else begin
                want = ex_err ? 7'b1111110 : seg_exp(w[idx*4 +: 4]);
                if (seg !== want) bad_seg++;
                if (prev < 0) begin
                    prev = idx;
                    run  = 1;
                end else if (idx == prev) begin
                    run++;
                end else begin
                    if (idx != (prev + 1) % 4) bad_rot++;
                    if (trans > 0 && run != RC) bad_rot++;
                    trans++;
                    prev = idx;
                    run  = 1;
                end
            end
        end
        chk({tag, "_onehot"}, bad_oh, 0);
        chk({tag, "_segs"}, bad_seg, 0);
        chk({tag, "_rotate"}, bad_rot, 0);
        chk({tag, "_advances"}, 32'(trans >= 7), 1);
    endtask

    // Monitor: every word_valid pulse pops one expected word
    always @(negedge clk) begin
        if (reset && word_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_word_valid: got word %0h expected none",
                         word);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("sb_word", word, mon_exp);
                chk("sb_err", err, 0);
            end
        end
    end

    initial begin
        // 1: reset state, idle scan
        repeat (3) @(posedge clk);
        #2;
        chk("rst_word", word, 16'h0000);
        chk("rst_an", {an3, an2, an1, an0}, 4'b1110);
        reset = 1'b1;
        @(negedge clk);
        chk("rel_word", word, 16'h0000);
        chk("rel_wv", word_valid, 0);
        chk("rel_err", err, 0);
        chk("rel_an", {an3, an2, an1, an0}, 4'b1110);
        chk("rel_seg", {a, b, c, d, e, f, g}, 7'b0000001);
        check_scan("idle", 16'h0000, 1'b0);

        // 2: back-to-back bytes, latency of word_valid
        exp_q.push_back(16'hDA8A);
        send2(8'hDA, 8'h8A);
        @(negedge clk);
        chk("lat_wv_hi", word_valid, 1);
        @(negedge clk);
        chk("lat_wv_lo", word_valid, 0);
        chk("t2_word", word, 16'hDA8A);
        check_scan("t2", 16'hDA8A, 1'b0);

        // 3: parity error with valid in WAIT_LO
        send_byte(8'h12, 1'b1, 1'b0, 1'b0);
        send_byte(8'h34, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("t3_err", err, 1);
        chk("t3_word", word, 16'hDA8A);
        check_scan("t3_dash", 16'hDA8A, 1'b1);
        send_byte(8'h56, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(16'h5678);
        send_byte(8'h78, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("t3_err_clr", err, 0);
        check_scan("t3", 16'h5678, 1'b0);

        // 4: timeout drops AB; CD..EF lands exactly on the expiry cycle
        send_byte(8'hAB, 1'b1, 1'b0, 1'b0);
        repeat (TC - 1) @(posedge clk);
        send_byte(8'hCD, 1'b1, 1'b0, 1'b0);
        repeat (TC - 2) @(posedge clk);
        exp_q.push_back(16'hCDEF);
        send_byte(8'hEF, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("t4_word", word, 16'hCDEF);
        chk("t4_err", err, 0);

        // 5: framing error while idle
        send_byte(8'h00, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("t5_err", err, 1);
        chk("t5_word", word, 16'hCDEF);
        send_byte(8'h31, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(16'h3147);
        send_byte(8'h47, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("t5_err_clr", err, 0);

        // 6: async reset while in WAIT_LO with err set
        send_byte(8'h00, 1'b0, 1'b0, 1'b1);
        send_byte(8'h99, 1'b1, 1'b0, 1'b0);
        #3;
        reset = 1'b0;
        #1;
        chk("ar_word", word, 16'h0000);
        chk("ar_err", err, 0);
        chk("ar_wv", word_valid, 0);
        chk("ar_an", {an3, an2, an1, an0}, 4'b1110);
        chk("ar_seg", {a, b, c, d, e, f, g}, 7'b0000001);
        #12;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        send_byte(8'h11, 1'b1, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        exp_q.push_back(16'h1122);
        send_byte(8'h22, 1'b1, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        chk("t6_word", word, 16'h1122);
        chk("sb_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_word_display.md
Name: uart_word_display

Overview:
- Sits directly downstream of the UART receiver in the UART-to-LED path and consumes its Rx_DATA / Rx_VALID / Rx_FERROR / Rx_PERROR outputs.
- Assembles consecutive good bytes into 16-bit words, high byte first.
- Holds the last complete word and shows it as four hex digits on a time-multiplexed, active-low 4-digit seven-segment display.
- Reports receive errors and exposes the assembled word to other logic.

Parameters:
- REFRESH_CYCLES, 50000: clk cycles each digit stays lit (1 ms at 50 MHz); must be >=2.
- TIMEOUT_CYCLES, 500000: clk cycles allowed between the high and low byte before the partial word is dropped (10 ms at 50 MHz); must be >=2.

Ports:
- clk  in  1  system clock, 50 MHz nominal
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- Rx_DATA  in  8  received byte; valid only when Rx_VALID=1
- Rx_VALID  in  1  1-cycle pulse: Rx_DATA holds a newly received byte
- Rx_FERROR  in  1  framing error on the current reception
- Rx_PERROR  in  1  parity error on the current reception
- word  out  16  last complete word, {high byte, low byte}
- word_valid  out  1  1-cycle pulse when word updates
- err  out  1  sticky error flag; cleared only by the next complete good word
- an3, an2, an1, an0  out  1 each  digit anodes, active-low; an3 = most significant nibble
- a, b, c, d, e, f, g  out  1 each  segment cathodes, active-low

Behaviour:
- All outputs are registered.
- Good byte: Rx_VALID=1 and Rx_FERROR=0 and Rx_PERROR=0 in the same cycle.
- Error event: Rx_FERROR=1 or Rx_PERROR=1 in any cycle, whatever the state of Rx_VALID. An error event always wins over a simultaneous Rx_VALID.
- Reset values:
  - word=16'h0000, word_valid=0, err=0
  - FSM=WAIT_HI, digit index=0, refresh counter=0, timeout counter=0
  - an0=0, an1=an2=an3=1
  - segments show '0': a..f=0, g=1
- Assembly FSM:
  - WAIT_HI: on a good byte, latch hi_byte<=Rx_DATA, clear the timeout counter, go to WAIT_LO.
  - WAIT_LO, good byte: word<={hi_byte, Rx_DATA}; word_valid=1 on the next cycle only; err<=0; go to WAIT_HI.
  - WAIT_LO, error event: discard hi_byte, err<=1, go to WAIT_HI.
  - WAIT_LO, no good byte for TIMEOUT_CYCLES consecutive cycles: discard hi_byte, go to WAIT_HI. err is unchanged.
  - WAIT_LO, timeout expiry and a good byte in the same cycle: the byte completes the word.
  - WAIT_HI, error event: err<=1; state is unchanged.
  - word is unchanged by errors and timeouts.
- Latency: word and word_valid update 1 clk after the Rx_VALID cycle of the low byte. The display reflects the new word at the next digit-advance at the latest (bounded by REFRESH_CYCLES).
- Display scan:
  - The refresh counter counts 0..REFRESH_CYCLES-1 and wraps to 0.
  - On wrap, the digit index advances 0->1->2->3->0.
  - Exactly one anode is low at any time: index 0 drives an0 with word[3:0], ... index 3 drives an3 with word[15:12].
  - Anodes and segments change in the same clk edge, so there is no ghosting cycle.
- Hex decode:
  - Standard 7-segment patterns for 0-9 and A, b, C, d, E, F.
  - Active-low; examples: '0'=abcdef, '1'=bc, 'A'=abcefg, 'F'=aefg.
- While err=1, every digit shows a dash: only g=0, a..f=1. The scan continues normally.
- Reset asserted mid-operation: state returns immediately and asynchronously to the reset values above, and any partial hi_byte is lost.
- Back-to-back Rx_VALID pulses on adjacent cycles are each accepted. There is no minimum spacing.

Test Plan:
1. Reset release, no traffic -> word=0000, err=0, anodes rotate an0->an1->an2->an3 every REFRESH_CYCLES clks (set 8 in sim), all digits show '0'.
2. Good bytes 8'hDA then 8'h8A -> one word_valid pulse 1 clk after the second Rx_VALID; word=16'hDA8A; scan shows an3='d', an2='A', an1='8', an0='A'.
3. Good 8'h12, then a cycle with Rx_VALID=1 and Rx_PERROR=1 carrying 8'h34 -> no word_valid, word stays DA8A, err=1, all digits show a dash. Then 8'h56, 8'h78 -> word=5678, err=0.
4. Good 8'hAB, then idle for TIMEOUT_CYCLES (set 20 in sim), then 8'hCD, 8'hEF -> the first word_valid gives word=CDEF, not ABCD; err stays 0.
5. Rx_FERROR pulse while in WAIT_HI -> err=1, word unchanged. Two good bytes follow -> err clears with the new word.
6. reset driven low asynchronously (between clk edges) while in WAIT_LO -> outputs go to reset values immediately. After release, a single byte 8'h11 does not produce word_valid.
